// File: rtl/tdm_demux_if.sv
// Word-serial TDM stream in, per-lane registers and strobes out.
// TDM_DEMUX_PARITY_EN adds the in_parity / parity_err pair.
interface tdm_demux_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_sync;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_valid;
  logic                   frame_done;
  logic                   sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic                   in_parity;
  logic                   parity_err;

  modport master (
    output in_data, in_valid, in_sync, in_parity,
    input  out_data, out_valid, frame_done, sync_err, parity_err
  );
  modport slave (
    input  in_data, in_valid, in_sync, in_parity,
    output out_data, out_valid, frame_done, sync_err, parity_err
  );
`else
  modport master (
    output in_data, in_valid, in_sync,
    input  out_data, out_valid, frame_done, sync_err
  );
  modport slave (
    input  in_data, in_valid, in_sync,
    output out_data, out_valid, frame_done, sync_err
  );
`endif
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: locks to a frame-sync marker and routes each word to its lane.
// Optional even-parity checking is enabled with `define TDM_DEMUX_PARITY_EN.
module tdm_demux #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input logic       clk,
  input logic       rst,
  tdm_demux_if.slave bus
);
  localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(LANES - 1);
  localparam logic [SW-1:0] ONE_SLOT  = SW'(1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                 state, state_n;
  logic [SW-1:0]          slot, slot_n;
  logic [LANES-1:0]       hit;
  logic [LANES-1:0]       valid_n, valid_q;
  logic [LANES*WIDTH-1:0] lanes_q;
  logic                   frame_n, frame_q;
  logic                   serr_n, serr_q;
  logic                   word_ok;

`ifdef TDM_DEMUX_PARITY_EN
  logic perr_n, perr_q;
  assign word_ok = ~^{bus.in_data, bus.in_parity};
  assign perr_n  = (|hit) & ~word_ok;
`else
  assign word_ok = 1'b1;
`endif

  // hit marks the lane this word targets; a parity-bad word still steers the slot
  // counter but its strobe is suppressed.
  always_comb begin
    state_n = state;
    slot_n  = slot;
    hit     = '0;
    frame_n = 1'b0;
    serr_n  = 1'b0;
    if (bus.in_valid) begin
      unique case (state)
        HUNT: begin
          if (bus.in_sync) begin
            hit[0] = 1'b1;
            if (word_ok) begin
              state_n = LOCKED;
              slot_n  = ONE_SLOT;
            end
          end
        end
        LOCKED: begin
          if (bus.in_sync && (slot != '0)) begin
            serr_n = 1'b1;
            hit[0] = 1'b1;
            slot_n = ONE_SLOT;
          end else begin
            hit[slot] = 1'b1;
            frame_n   = (slot == LAST_SLOT);
            slot_n    = (slot == LAST_SLOT) ? '0 : slot + ONE_SLOT;
          end
        end
        default: state_n = HUNT;
      endcase
    end
    valid_n = word_ok ? hit : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      slot  <= '0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q <= '0;
      valid_q <= '0;
      frame_q <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (valid_n[k]) lanes_q[k*WIDTH +: WIDTH] <= bus.in_data;
      end
      valid_q <= valid_n;
      frame_q <= frame_n;
      serr_q  <= serr_n;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_n;
  end
  assign bus.parity_err = perr_q;
`endif

  assign bus.out_data   = lanes_q;
  assign bus.out_valid  = valid_q;
  assign bus.frame_done = frame_q;
  assign bus.sync_err   = serr_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (WIDTH=8, LANES=4).
// Parity scenarios are compiled in with `define TDM_DEMUX_PARITY_EN.
module tb_tdm_demux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  tdm_demux_if #(.WIDTH(8), .LANES(4)) bus ();
  tdm_demux #(.WIDTH(8), .LANES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] lane(input int k);
    return bus.out_data[k*8 +: 8];
  endfunction

  // Drive one cycle of stimulus at negedge; return 1ns after the following posedge.
  task automatic drive(input logic [7:0] d, input logic s, input logic v, input logic bad);
    @(negedge clk);
    bus.in_data  = d;
    bus.in_sync  = s;
    bus.in_valid = v;
`ifdef TDM_DEMUX_PARITY_EN
    bus.in_parity = (^d) ^ bad;
`else
    if (bad) $display("note: parity request ignored in this build");
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = '0;
`ifdef TDM_DEMUX_PARITY_EN
    bus.in_parity = 1'b0;
`endif
    rst = 1'b1;
    #12;
    checks++;
    if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h want=00000000", bus.out_data); end
    checks++;
    if ({bus.out_valid, bus.frame_done, bus.sync_err} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got=%b want=000000", {bus.out_valid, bus.frame_done, bus.sync_err});
    end
`ifdef TDM_DEMUX_PARITY_EN
    checks++;
    if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b want=0", bus.parity_err); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_frame();
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] ev;
    for (int i = 0; i < 4; i++) begin
      drive(d[i], i == 0, 1'b1, 1'b0);
      ev = 4'b0001 << i;
      checks++;
      if (bus.out_valid !== ev) begin errors++; $display("FAIL frame_valid%0d got=%b want=%b", i, bus.out_valid, ev); end
      checks++;
      if (lane(i) !== d[i]) begin errors++; $display("FAIL frame_lane%0d got=%h want=%h", i, lane(i), d[i]); end
      checks++;
      if (bus.frame_done !== (i == 3)) begin errors++; $display("FAIL frame_done%0d got=%b want=%b", i, bus.frame_done, i == 3); end
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.out_data !== 32'h44332211) begin errors++; $display("FAIL frame_all got=%h want=44332211", bus.out_data); end
    checks++;
    if ({bus.out_valid, bus.frame_done} !== 5'b0) begin
      errors++; $display("FAIL frame_idle got=%b want=00000", {bus.out_valid, bus.frame_done});
    end
  endtask

  task automatic test_hunt();
    do_reset();
    drive(8'hAA, 1'b0, 1'b1, 1'b0);
    drive(8'hBB, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL hunt_valid got=%b want=0000", bus.out_valid); end
    checks++;
    if (bus.out_data !== 32'h0) begin errors++; $display("FAIL hunt_data got=%h want=00000000", bus.out_data); end
    drive(8'h01, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 4'b0001 || lane(0) !== 8'h01) begin
      errors++; $display("FAIL hunt_lock got=%b/%h want=0001/01", bus.out_valid, lane(0));
    end
    drive(8'h02, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 4'b0010 || lane(1) !== 8'h02) begin
      errors++; $display("FAIL hunt_locked got=%b/%h want=0010/02", bus.out_valid, lane(1));
    end
  endtask

  task automatic test_sync_err();
    do_reset();
    drive(8'h10, 1'b1, 1'b1, 1'b0);
    drive(8'h20, 1'b0, 1'b1, 1'b0);
    drive(8'h30, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.sync_err !== 1'b1) begin errors++; $display("FAIL serr_pulse got=%b want=1", bus.sync_err); end
    checks++;
    if (bus.out_valid !== 4'b0001 || lane(0) !== 8'h30 || lane(1) !== 8'h20) begin
      errors++; $display("FAIL serr_realign got=%b/%h/%h want=0001/30/20", bus.out_valid, lane(0), lane(1));
    end
    drive(8'h40, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 4'b0010 || lane(1) !== 8'h40) begin
      errors++; $display("FAIL serr_next got=%b/%h want=0010/40", bus.out_valid, lane(1));
    end
    checks++;
    if (bus.sync_err !== 1'b0 || bus.frame_done !== 1'b0) begin
      errors++; $display("FAIL serr_clear got=%b%b want=00", bus.sync_err, bus.frame_done);
    end
  endtask

  task automatic test_back_to_back();
    // valid, sync, data; gaps have valid=0
    logic [9:0] seq [12] = '{
      {1'b1, 1'b1, 8'hA1}, {1'b1, 1'b0, 8'hA2}, {1'b0, 1'b0, 8'hFF}, {1'b1, 1'b0, 8'hA3},
      {1'b1, 1'b0, 8'hA4}, {1'b1, 1'b1, 8'hB1}, {1'b1, 1'b0, 8'hB2}, {1'b0, 1'b1, 8'hEE},
      {1'b0, 1'b0, 8'hDD}, {1'b1, 1'b0, 8'hB3}, {1'b1, 1'b0, 8'hB4}, {1'b0, 1'b0, 8'h00}};
    int fd = 0;
    int serr = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(seq[i][7:0], seq[i][8], seq[i][9], 1'b0);
      fd   += int'(bus.frame_done);
      serr += int'(bus.sync_err);
      if (!seq[i][9]) begin
        checks++;
        if ({bus.out_valid, bus.frame_done} !== 5'b0) begin
          errors++; $display("FAIL b2b_gap%0d got=%b want=00000", i, {bus.out_valid, bus.frame_done});
        end
      end
    end
    checks++;
    if (bus.out_data !== 32'hB4B3B2B1) begin errors++; $display("FAIL b2b_lanes got=%h want=B4B3B2B1", bus.out_data); end
    checks++;
    if (fd !== 2) begin errors++; $display("FAIL b2b_frames got=%0d want=2", fd); end
    checks++;
    if (serr !== 0) begin errors++; $display("FAIL b2b_serr got=%0d want=0", serr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(8'h61, 1'b1, 1'b1, 1'b0);
    drive(8'h62, 1'b0, 1'b1, 1'b0);
    drive(8'h63, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 4'b0100 || bus.out_data !== 32'h00636261) begin
      errors++; $display("FAIL arst_pre got=%b/%h want=0100/00636261", bus.out_valid, bus.out_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_data !== 32'h0 || bus.out_valid !== 4'b0) begin
      errors++; $display("FAIL arst_clear got=%b/%h want=0000/00000000", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(8'h77, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 4'b0 || bus.out_data !== 32'h0) begin
      errors++; $display("FAIL arst_hunt got=%b/%h want=0000/00000000", bus.out_valid, bus.out_data);
    end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    do_reset();
    drive(8'h01, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.parity_err !== 1'b1 || bus.out_valid !== 4'b0) begin
      errors++; $display("FAIL par_hunt got=%b/%b want=1/0000", bus.parity_err, bus.out_valid);
    end
    drive(8'h09, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 4'b0 || bus.parity_err !== 1'b0) begin
      errors++; $display("FAIL par_nolock got=%b/%b want=0000/0", bus.out_valid, bus.parity_err);
    end
    drive(8'h01, 1'b1, 1'b1, 1'b0);
    drive(8'h03, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.parity_err !== 1'b1 || bus.out_valid !== 4'b0 || lane(1) !== 8'h00) begin
      errors++; $display("FAIL par_bad got=%b/%b/%h want=1/0000/00", bus.parity_err, bus.out_valid, lane(1));
    end
    drive(8'h07, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 4'b0100 || lane(2) !== 8'h07 || bus.parity_err !== 1'b0) begin
      errors++; $display("FAIL par_slot2 got=%b/%h/%b want=0100/07/0", bus.out_valid, lane(2), bus.parity_err);
    end
    drive(8'h0F, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 4'b1000 || bus.frame_done !== 1'b1) begin
      errors++; $display("FAIL par_frame got=%b/%b want=1000/1", bus.out_valid, bus.frame_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_hunt();
    test_sync_err();
    test_back_to_back();
    test_async_reset();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
